regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 32x32 register file. Shares it between the pipeline writeback stage and an auxiliary multi-cycle requester (mul/div unit or debug writer).
- After reset it sequences a hardware clear of all 32 registers, with $sp preset, replacing simulation-only initial values.
- Sits between the WB stage / aux unit and the register file's RegWrite/WriteReg/WriteData inputs. Adds no write latency in normal operation.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width (32 registers)
SP_REG, 29, index of stack pointer register
SP_INIT, 252, value loaded into SP_REG during clear (top of data memory, byte address)
STARVE_LIMIT, 4, consecutive denied aux cycles before WB hold is requested (1..15)

Ports:
Clk  in  1  clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
WbRegWrite  in  1  writeback write request; no backpressure
WbWriteReg  in  ADDR_W  writeback destination
WbWriteData  in  DATA_W  writeback data
AuxValid  in  1  aux request valid; held with reg/data stable until accepted
AuxWriteReg  in  ADDR_W  aux destination
AuxWriteData  in  DATA_W  aux data
AuxReady  out  1  aux request accepted this cycle (valid&ready = transfer)
WbHold  out  1  request to pipeline: present no WB write next cycle
InitBusy  out  1  clear in progress; pipeline must stall
RegWrite  out  1  to register file write enable
WriteReg  out  ADDR_W  to register file write index
WriteData  out  DATA_W  to register file write data

Behaviour:
- State: FSM {INIT, RUN}; InitIdx counter (ADDR_W bits); StarveCnt counter (4 bits, saturating).
- Reset=1 at posedge: state<=INIT, InitIdx<=0, StarveCnt<=0.
- While Reset=1: RegWrite, AuxReady, WbHold forced 0 combinationally; InitBusy=1.
- INIT:
  - Each cycle: RegWrite=1, WriteReg=InitIdx, WriteData = (InitIdx==SP_REG) ? SP_INIT : 0.
  - InitIdx increments each cycle. After InitIdx=31 is written, state<=RUN.
  - Clear takes exactly 32 cycles after reset release.
  - InitBusy=1, AuxReady=0, WbHold=0. WB and aux inputs are ignored; a WB write arriving in INIT is dropped (pipeline contract: stalled).
- RUN:
  - Output mux and grant are combinational from inputs and state; zero added latency.
  - Priority: WbRegWrite=1 -> WB owns the port: WriteReg/WriteData=Wb*, AuxReady=0.
  - Else AuxValid=1 -> AuxReady=1, WriteReg/WriteData=Aux*.
  - Else RegWrite=0; WriteReg/WriteData = Wb* (don't-care, not checked).
  - Register 0 protection: if the granted destination is 0, RegWrite=0. Grant and handshake still complete (AuxReady=1 if aux was chosen).
  - InitBusy=0.
- Starvation guard (RUN only):
  - StarveCnt increments when AuxValid&!AuxReady, saturating at STARVE_LIMIT.
  - StarveCnt clears on an aux transfer or when AuxValid=0.
  - WbHold = (StarveCnt==STARVE_LIMIT).
  - Pipeline honours WbHold by holding WbRegWrite=0, so aux wins that cycle and the counter clears.
  - If WbRegWrite=1 despite WbHold, WB still wins (never drop a WB write) and WbHold stays asserted.
- Simultaneous WB and aux writes to the same register: WB write committed; aux write committed in a later cycle (aux value lands last). Ordering is the aux unit's responsibility.
- Reset mid-INIT or mid-RUN: restarts clear from index 0. A pending aux request is not accepted until RUN. StarveCnt cleared.

Test Plan:
- Reset high 2 cycles, release -> 32 consecutive writes idx 0..31; data 0 except idx29=252; InitBusy falls in cycle 33; registers read 0 / reg29=252.
- RUN, WbRegWrite=1 reg8 data 0x11, AuxValid=0 -> RegWrite=1, WriteReg=8, WriteData=0x11 same cycle, AuxReady=0.
- RUN, WB reg9=0x22 and Aux reg10=0xAB same cycle, then WB idle -> cycle1 writes reg9 (AuxReady=0), cycle2 writes reg10=0xAB with AuxReady=1.
- STARVE_LIMIT=4, WbRegWrite=1 every cycle, AuxValid=1 -> WbHold rises after 4 denied cycles; bench drops WB -> aux granted, WbHold returns 0 next cycle.
- Aux write to reg0 data 0xFFFF -> AuxReady=1, RegWrite=0, reg0 reads 0. WB write to reg0 -> RegWrite=0.
- Reset asserted at clear index 12 -> clear restarts at index 0 and completes 32 cycles after release; aux held valid throughout is accepted only in first RUN cycle.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates the register-file write port between WB and an aux requester, with post-reset clear.
module regfile_write_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SP_REG = 29,
  parameter int SP_INIT = 252,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WbRegWrite,
  input  logic [ADDR_W-1:0] WbWriteReg,
  input  logic [DATA_W-1:0] WbWriteData,
  input  logic              AuxValid,
  input  logic [ADDR_W-1:0] AuxWriteReg,
  input  logic [DATA_W-1:0] AuxWriteData,
  output logic              AuxReady,
  output logic              WbHold,
  output logic              InitBusy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(SP_REG);
  localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] init_idx;
  logic [3:0] starve_cnt, starve_nxt;
  logic run, aux_grant;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= INIT;
      init_idx <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      init_idx <= state == INIT ? init_idx + 1'b1 : init_idx;
      starve_cnt <= starve_nxt;
    end
  end
  // Reset gates everything combinationally so nothing reaches the regfile while it is held.
  always_comb begin
    run = state == RUN && !Reset;
    aux_grant = run && !WbRegWrite && AuxValid;
    state_nxt = (state == INIT && init_idx == '1) ? RUN : state;
    starve_nxt = (!run || !AuxValid || aux_grant) ? 4'd0 :
                 (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
    InitBusy = !run;
    AuxReady = aux_grant;
    WbHold = run && starve_cnt == LIMIT;
    WriteReg = !run ? init_idx : aux_grant ? AuxWriteReg : WbWriteReg;
    WriteData = !run ? (init_idx == SP_IDX ? SP_VAL : '0) :
                aux_grant ? AuxWriteData : WbWriteData;
    RegWrite = !Reset && (!run || ((WbRegWrite || AuxValid) && WriteReg != '0));
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: scoreboard bench; stimulus queues expected port writes, monitor checks them.
module tb_regfile_write_scheduler;
  logic Clk = 0, Reset = 1;
  logic WbRegWrite = 0, AuxValid = 0;
  logic [4:0] WbWriteReg = 0, AuxWriteReg = 0;
  logic [31:0] WbWriteData = 0, AuxWriteData = 0;
  logic AuxReady, WbHold, InitBusy, RegWrite;
  logic [4:0] WriteReg;
  logic [31:0] WriteData;
  typedef struct packed {logic [4:0] r; logic [31:0] d; logic we, ar, hold;} ev_t;
  ev_t q[$];
  ev_t act, expv;
  logic [31:0] shadow [32];
  int checks = 0, errors = 0;
  regfile_write_scheduler dut (
    .Clk(Clk), .Reset(Reset),
    .WbRegWrite(WbRegWrite), .WbWriteReg(WbWriteReg), .WbWriteData(WbWriteData),
    .AuxValid(AuxValid), .AuxWriteReg(AuxWriteReg), .AuxWriteData(AuxWriteData),
    .AuxReady(AuxReady), .WbHold(WbHold), .InitBusy(InitBusy),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );
  always #5 Clk = ~Clk;
  always @(negedge Clk) begin
    if (RegWrite || AuxReady) begin
      act = '{WriteReg, WriteData, RegWrite, AuxReady, WbHold};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got reg=%0d data=%h we=%b ar=%b hold=%b, none expected",
                 act.r, act.d, act.we, act.ar, act.hold);
      end else begin
        expv = q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL write_event: got reg=%0d data=%h we=%b ar=%b hold=%b, want reg=%0d data=%h we=%b ar=%b hold=%b",
                   act.r, act.d, act.we, act.ar, act.hold, expv.r, expv.d, expv.we, expv.ar, expv.hold);
        end
      end
      if (RegWrite) shadow[WriteReg] = WriteData;
    end
  end
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask
  task automatic push(input logic [4:0] r, input logic [31:0] d, input logic we, ar, hold);
    q.push_back('{r, d, we, ar, hold});
  endtask
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, a, e);
    end
  endtask
  task automatic wb(input logic v, input logic [4:0] r, input logic [31:0] d);
    WbRegWrite = v; WbWriteReg = r; WbWriteData = d;
  endtask
  task automatic aux(input logic v, input logic [4:0] r, input logic [31:0] d);
    AuxValid = v; AuxWriteReg = r; AuxWriteData = d;
  endtask
  task automatic clear_run(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) cyc();
      push(5'(i), i == 29 ? 32'd252 : 32'd0, 1, 0, 0);
      @(negedge Clk);
      if (i == 0 || i == 31) chk("init_busy_clear", {31'd0, InitBusy}, 1);
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 32'hDEADBEEF;
    wb(1, 5, 32'h99);
    aux(1, 6, 32'h66);
    cyc();
    cyc();
    @(negedge Clk);
    chk("reset_regwrite", {31'd0, RegWrite}, 0);
    chk("reset_auxready", {31'd0, AuxReady}, 0);
    chk("reset_wbhold", {31'd0, WbHold}, 0);
    chk("reset_initbusy", {31'd0, InitBusy}, 1);
    cyc();
    Reset = 0;
    aux(0, 0, 0);
    clear_run(32);
    cyc();
    wb(0, 0, 0);
    @(negedge Clk);
    chk("init_busy_fall", {31'd0, InitBusy}, 0);
    cyc();
    for (int i = 0; i < 32; i++) chk($sformatf("cleared_reg%0d", i), shadow[i], i == 29 ? 252 : 0);
    wb(1, 8, 32'h11);
    push(8, 32'h11, 1, 0, 0);
    cyc();
    wb(1, 9, 32'h22);
    aux(1, 10, 32'hAB);
    push(9, 32'h22, 1, 0, 0);
    cyc();
    wb(0, 0, 0);
    push(10, 32'hAB, 1, 1, 0);
    cyc();
    aux(0, 0, 0);
    cyc();
    aux(1, 4, 32'h44);
    for (int k = 0; k < 6; k++) begin
      wb(1, 3, 32'(k));
      push(3, 32'(k), 1, 0, k >= 4);
      cyc();
    end
    wb(0, 0, 0);
    push(4, 32'h44, 1, 1, 1);
    cyc();
    aux(0, 0, 0);
    @(negedge Clk);
    chk("wbhold_release", {31'd0, WbHold}, 0);
    chk("shadow_reg4", shadow[4], 32'h44);
    cyc();
    aux(1, 0, 32'hFFFF);
    push(0, 32'hFFFF, 0, 1, 0);
    cyc();
    aux(0, 0, 0);
    wb(1, 0, 32'h77);
    @(negedge Clk);
    chk("wb_reg0_regwrite", {31'd0, RegWrite}, 0);
    cyc();
    wb(0, 0, 0);
    chk("reg0_zero", shadow[0], 0);
    Reset = 1;
    aux(1, 11, 32'h5A);
    cyc();
    Reset = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      push(5'(i), 32'd0, 1, 0, 0);
    end
    cyc();
    Reset = 1;
    @(negedge Clk);
    chk("midclear_reset_regwrite", {31'd0, RegWrite}, 0);
    cyc();
    Reset = 0;
    clear_run(32);
    cyc();
    push(11, 32'h5A, 1, 1, 0);
    @(negedge Clk);
    chk("first_run_auxready", {31'd0, AuxReady}, 1);
    cyc();
    aux(0, 0, 0);
    cyc();
    cyc();
    chk("scoreboard_drained", q.size(), 0);
    chk("shadow_reg11", shadow[11], 32'h5A);
    chk("shadow_reg29", shadow[29], 252);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
